// File: rtl/xmem_regbank.sv
// xmem_regbank: AVR external-memory slave register bank.
// Decodes the 256-byte window BASE_HI:xx and exposes per-channel motor,
// encoder and servo buses, plus atomic 16-bit encoder reads, staged servo
// commits and a motor-safety watchdog.
// Ports:
//   clk, nRST             clock, async active-low reset
//   a, ad_i, ale          high address byte, AD bus input, address latch enable
//   nRD, nWR              raw active-low read/write strobes
//   ad_o, ad_oe           AD bus read data and output enable
//   aout, ramce           latched low address and SRAM chip enable
//   mot_ctl, mot_vel      per-motor control and velocity (velocity masked on trip)
//   enc_cnt               per-encoder 16-bit counts
//   srv_pos, srv_en       per-servo committed position and enable
//   digital               digital inputs
//   wdog_trip             watchdog tripped
module xmem_regbank #(
    parameter logic [7:0]  BASE_HI   = 8'h11,
    parameter int unsigned NUM_MOTOR = 6,
    parameter int unsigned NUM_ENC   = 4,
    parameter int unsigned NUM_SERVO = 6,
    parameter int unsigned WDOG_W    = 24,
    parameter logic [7:0]  VER_MAJ   = 8'd1,
    parameter logic [7:0]  VER_MIN   = 8'd0
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [7:0]               a,
    input  logic [7:0]               ad_i,
    output logic [7:0]               ad_o,
    output logic                     ad_oe,
    input  logic                     ale,
    input  logic                     nRD,
    input  logic                     nWR,
    output logic [7:0]               aout,
    output logic                     ramce,
    output logic [2*NUM_MOTOR-1:0]   mot_ctl,
    output logic [8*NUM_MOTOR-1:0]   mot_vel,
    input  logic [16*NUM_ENC-1:0]    enc_cnt,
    output logic [10*NUM_SERVO-1:0]  srv_pos,
    output logic [NUM_SERVO-1:0]     srv_en,
    input  logic [7:0]               digital,
    output logic                     wdog_trip
);

    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

    typedef enum logic [1:0] {IDLE, RD, WR} state_e;

    logic [15:0]       addr_q;
    logic              nrd_s1_q, nrd_s2_q, nrd_s3_q;
    logic              nwr_s1_q, nwr_s2_q, nwr_s3_q;
    state_e            state_q;
    logic [7:0]        ad_o_q;
    logic [7:0]        wdata_q;
    logic [1:0]        ctl_q    [NUM_MOTOR];
    logic [7:0]        vel_q    [NUM_MOTOR];
    logic [7:0]        shadow_q [NUM_ENC];
    logic [7:0]        stage_q  [NUM_SERVO];
    logic [9:0]        pos_q    [NUM_SERVO];
    logic              en_q     [NUM_SERVO];
    logic [WDOG_W-1:0] wdog_cnt_q;
    logic              wdog_trip_q;

    logic       hit_c;
    logic [7:0] off_c;
    logic [4:0] idx_c;
    logic       nrd_fall_c, nrd_rise_c, nwr_fall_c, nwr_rise_c;
    logic       wr_start_c, rd_start_c, commit_c;
    logic [7:0] rdata_c;

    assign hit_c      = (addr_q[15:8] == BASE_HI);
    assign off_c      = addr_q[7:0];
    assign idx_c      = off_c[5:1];
    assign nrd_fall_c = nrd_s3_q & ~nrd_s2_q;
    assign nrd_rise_c = ~nrd_s3_q & nrd_s2_q;
    assign nwr_fall_c = nwr_s3_q & ~nwr_s2_q;
    assign nwr_rise_c = ~nwr_s3_q & nwr_s2_q;
    assign wr_start_c = (state_q == IDLE) && nwr_fall_c && hit_c;
    // A read is ignored whenever the write strobe is (or just went) low.
    assign rd_start_c = (state_q == IDLE) && nrd_fall_c && hit_c && nwr_s2_q && !wr_start_c;
    assign commit_c   = (state_q == WR) && nwr_rise_c && hit_c;

    assign aout      = addr_q[7:0];
    assign ramce     = ~addr_q[15];
    assign ad_o      = ad_o_q;
    assign ad_oe     = hit_c && !nRD && (state_q != WR);
    assign wdog_trip = wdog_trip_q;

    // Address latch and strobe synchronisers (third stage for edge detect).
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            addr_q   <= '0;
            nrd_s1_q <= 1'b1;
            nrd_s2_q <= 1'b1;
            nrd_s3_q <= 1'b1;
            nwr_s1_q <= 1'b1;
            nwr_s2_q <= 1'b1;
            nwr_s3_q <= 1'b1;
        end else begin
            if (ale) begin
                addr_q <= {a, ad_i};
            end
            nrd_s1_q <= nRD;
            nrd_s2_q <= nrd_s1_q;
            nrd_s3_q <= nrd_s2_q;
            nwr_s1_q <= nWR;
            nwr_s2_q <= nwr_s1_q;
            nwr_s3_q <= nwr_s2_q;
        end
    end

    // Read data mux over the register window.
    always_comb begin
        rdata_c = 8'h00;
        case (off_c[7:6])
            2'b00: begin
                for (int k = 0; k < int'(NUM_MOTOR); k++) begin
                    if (idx_c == 5'(k)) begin
                        rdata_c = off_c[0] ? vel_q[k] : {6'b0, ctl_q[k]};
                    end
                end
            end
            2'b01: begin
                for (int k = 0; k < int'(NUM_ENC); k++) begin
                    if (idx_c == 5'(k)) begin
                        rdata_c = off_c[0] ? shadow_q[k] : enc_cnt[16*k +: 8];
                    end
                end
            end
            2'b10: begin
                for (int k = 0; k < int'(NUM_SERVO); k++) begin
                    if (idx_c == 5'(k)) begin
                        rdata_c = off_c[0] ? {en_q[k], 5'b0, pos_q[k][9:8]} : stage_q[k];
                    end
                end
            end
            default: begin
                case (off_c)
                    8'hC0:   rdata_c = digital;
                    8'hC1:   rdata_c = {7'b0, wdog_trip_q};
                    8'hFE:   rdata_c = VER_MAJ;
                    8'hFF:   rdata_c = VER_MIN;
                    default: rdata_c = 8'h00;
                endcase
            end
        endcase
    end

    // Bus access FSM with registered read data and write capture.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            ad_o_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_start_c) begin
                        state_q <= WR;
                    end else if (rd_start_c) begin
                        state_q <= RD;
                        ad_o_q  <= rdata_c;
                    end
                end
                RD: begin
                    if (nrd_rise_c) begin
                        state_q <= IDLE;
                    end
                end
                WR: begin
                    wdata_q <= ad_i;
                    if (nwr_rise_c) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Channel registers, encoder shadows and watchdog.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < int'(NUM_MOTOR); k++) begin
                ctl_q[k] <= '0;
                vel_q[k] <= '0;
            end
            for (int k = 0; k < int'(NUM_ENC); k++) begin
                shadow_q[k] <= '0;
            end
            for (int k = 0; k < int'(NUM_SERVO); k++) begin
                stage_q[k] <= '0;
                pos_q[k]   <= '0;
                en_q[k]    <= 1'b0;
            end
            wdog_cnt_q  <= '0;
            wdog_trip_q <= 1'b0;
        end else begin
            // Low-byte encoder read freezes the high byte for the paired read.
            if (rd_start_c && (off_c[7:6] == 2'b01) && !off_c[0]) begin
                for (int k = 0; k < int'(NUM_ENC); k++) begin
                    if (idx_c == 5'(k)) begin
                        shadow_q[k] <= enc_cnt[16*k+8 +: 8];
                    end
                end
            end

            if (commit_c) begin
                if (off_c[7:6] == 2'b00) begin
                    for (int k = 0; k < int'(NUM_MOTOR); k++) begin
                        if (idx_c == 5'(k)) begin
                            if (off_c[0]) vel_q[k] <= wdata_q;
                            else          ctl_q[k] <= wdata_q[1:0];
                        end
                    end
                end
                if (off_c[7:6] == 2'b10) begin
                    for (int k = 0; k < int'(NUM_SERVO); k++) begin
                        if (idx_c == 5'(k)) begin
                            if (off_c[0]) begin
                                pos_q[k] <= {wdata_q[1:0], stage_q[k]};
                                en_q[k]  <= wdata_q[7];
                            end else begin
                                stage_q[k] <= wdata_q;
                            end
                        end
                    end
                end
            end

            // Any committed window write feeds the watchdog; it saturates once tripped.
            if (commit_c) begin
                wdog_cnt_q  <= '0;
                wdog_trip_q <= 1'b0;
            end else if (wdog_cnt_q != WDOG_MAX) begin
                wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
                if (wdog_cnt_q == WDOG_MAX - WDOG_W'(1)) begin
                    wdog_trip_q <= 1'b1;
                end
            end
        end
    end

    // Flatten per-channel registers; velocities read as zero while tripped.
    always_comb begin
        mot_ctl = '0;
        mot_vel = '0;
        srv_pos = '0;
        srv_en  = '0;
        for (int k = 0; k < int'(NUM_MOTOR); k++) begin
            mot_ctl[2*k +: 2] = ctl_q[k];
            mot_vel[8*k +: 8] = wdog_trip_q ? 8'h00 : vel_q[k];
        end
        for (int k = 0; k < int'(NUM_SERVO); k++) begin
            srv_pos[10*k +: 10] = pos_q[k];
            srv_en[k]           = en_q[k];
        end
    end

endmodule

// File: tb/tb_xmem_regbank.sv
// tb_xmem_regbank: directed self-checking bench for xmem_regbank.
module tb_xmem_regbank;

    logic        clk;
    logic        nRST;
    logic [7:0]  a;
    logic [7:0]  ad_i;
    logic [7:0]  ad_o;
    logic        ad_oe;
    logic        ale;
    logic        nRD;
    logic        nWR;
    logic [7:0]  aout;
    logic        ramce;
    logic [11:0] mot_ctl;
    logic [47:0] mot_vel;
    logic [63:0] enc_cnt;
    logic [59:0] srv_pos;
    logic [5:0]  srv_en;
    logic [7:0]  digital;
    logic        wdog_trip;

    int tests;
    int fails;

    xmem_regbank #(
        .BASE_HI  (8'h11),
        .NUM_MOTOR(6),
        .NUM_ENC  (4),
        .NUM_SERVO(6),
        .WDOG_W   (4),
        .VER_MAJ  (8'hA1),
        .VER_MIN  (8'h5A)
    ) dut (
        .clk      (clk),
        .nRST     (nRST),
        .a        (a),
        .ad_i     (ad_i),
        .ad_o     (ad_o),
        .ad_oe    (ad_oe),
        .ale      (ale),
        .nRD      (nRD),
        .nWR      (nWR),
        .aout     (aout),
        .ramce    (ramce),
        .mot_ctl  (mot_ctl),
        .mot_vel  (mot_vel),
        .enc_cnt  (enc_cnt),
        .srv_pos  (srv_pos),
        .srv_en   (srv_en),
        .digital  (digital),
        .wdog_trip(wdog_trip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latch address, then hold nWR low long enough to reach WR and capture data.
    task automatic start_write(input logic [15:0] addr, input logic [7:0] data);
        a    = addr[15:8];
        ad_i = addr[7:0];
        ale  = 1'b1;
        tick();
        ale  = 1'b0;
        ad_i = data;
        tick();
        nWR = 1'b0;
        repeat (4) tick();
    endtask

    // Full write; returns just after the commit edge.
    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        start_write(addr, data);
        nWR = 1'b1;
        repeat (3) tick();
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [7:0] d,
                            output logic oe_low, output logic oe_high);
        a    = addr[15:8];
        ad_i = addr[7:0];
        ale  = 1'b1;
        tick();
        ale  = 1'b0;
        ad_i = 8'h00;
        tick();
        nRD = 1'b0;
        repeat (4) tick();
        d      = ad_o;
        oe_low = ad_oe;
        nRD    = 1'b1;
        #1;
        oe_high = ad_oe;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        nRST = 1'b0; a = 8'h00; ad_i = 8'h00; ale = 1'b0; nRD = 1'b1; nWR = 1'b1;
        enc_cnt = '0; digital = 8'hA5;
        repeat (3) tick();
        tests++; if (ad_oe !== 1'b0) begin fails++; $display("FAIL reset_ad_oe: got %b expected 0", ad_oe); end
        tests++; if (ad_o !== 8'h00) begin fails++; $display("FAIL reset_ad_o: got %h expected 00", ad_o); end
        tests++; if (ramce !== 1'b1) begin fails++; $display("FAIL reset_ramce: got %b expected 1", ramce); end
        tests++; if (aout !== 8'h00) begin fails++; $display("FAIL reset_aout: got %h expected 00", aout); end
        tests++; if (wdog_trip !== 1'b0) begin fails++; $display("FAIL reset_trip: got %b expected 0", wdog_trip); end
        tests++; if ({mot_ctl, mot_vel} !== 60'h0) begin fails++; $display("FAIL reset_motor: got %h expected 0", {mot_ctl, mot_vel}); end
        tests++; if ({srv_pos, srv_en} !== 66'h0) begin fails++; $display("FAIL reset_servo: got %h expected 0", {srv_pos, srv_en}); end
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_write_read_vel();
        logic [7:0] d;
        logic       ol, oh;
        start_write(16'h1103, 8'h7F);
        nWR = 1'b1;
        repeat (2) tick();
        tests++; if (mot_vel[15:8] !== 8'h00) begin fails++; $display("FAIL vel_early: got %h expected 00", mot_vel[15:8]); end
        tick();
        tests++; if (mot_vel[15:8] !== 8'h7F) begin fails++; $display("FAIL vel_commit: got %h expected 7f", mot_vel[15:8]); end
        tests++; if (aout !== 8'h03) begin fails++; $display("FAIL vel_aout: got %h expected 03", aout); end
        bus_read(16'h1103, d, ol, oh);
        tests++; if (d !== 8'h7F) begin fails++; $display("FAIL vel_read: got %h expected 7f", d); end
        tests++; if (ol !== 1'b1) begin fails++; $display("FAIL vel_read_oe: got %b expected 1", ol); end
        // ctl keeps only bits 1:0
        bus_write(16'h1102, 8'hFF);
        tests++; if (mot_ctl[3:2] !== 2'b11) begin fails++; $display("FAIL ctl_out: got %b expected 11", mot_ctl[3:2]); end
        bus_read(16'h1102, d, ol, oh);
        tests++; if (d !== 8'h03) begin fails++; $display("FAIL ctl_read: got %h expected 03", d); end
        bus_read(16'h110C, d, ol, oh);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL motor_oor_read: got %h expected 00", d); end
    endtask

    task automatic test_encoder();
        logic [7:0] d;
        logic       ol, oh;
        enc_cnt[15:0] = 16'h12FF;
        bus_read(16'h1140, d, ol, oh);
        tests++; if (d !== 8'hFF) begin fails++; $display("FAIL enc_lo: got %h expected ff", d); end
        enc_cnt[15:0] = 16'h1300;
        bus_read(16'h1141, d, ol, oh);
        tests++; if (d !== 8'h12) begin fails++; $display("FAIL enc_hi_shadow: got %h expected 12", d); end
        enc_cnt[31:16] = 16'hBEEF;
        bus_read(16'h1143, d, ol, oh);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL enc1_hi_unloaded: got %h expected 00", d); end
        bus_read(16'h1150, d, ol, oh);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL enc_oor_read: got %h expected 00", d); end
        bus_read(16'h11C0, d, ol, oh);
        tests++; if (d !== 8'hA5) begin fails++; $display("FAIL digital_read: got %h expected a5", d); end
    endtask

    task automatic test_servo();
        logic [7:0] d;
        logic       ol, oh;
        bus_write(16'h1180, 8'h34);
        bus_write(16'h1182, 8'h56);
        bus_write(16'h1181, 8'h82);
        tests++; if (srv_pos[9:0] !== 10'h234) begin fails++; $display("FAIL srv0_pos: got %h expected 234", srv_pos[9:0]); end
        tests++; if (srv_en[0] !== 1'b1) begin fails++; $display("FAIL srv0_en: got %b expected 1", srv_en[0]); end
        tests++; if ({srv_pos[19:10], srv_en[1]} !== 11'h0) begin fails++; $display("FAIL srv1_untouched: got %h expected 0", {srv_pos[19:10], srv_en[1]}); end
        bus_read(16'h1181, d, ol, oh);
        tests++; if (d !== 8'h82) begin fails++; $display("FAIL srv0_hi_read: got %h expected 82", d); end
        bus_read(16'h1182, d, ol, oh);
        tests++; if (d !== 8'h56) begin fails++; $display("FAIL srv1_stage_read: got %h expected 56", d); end
    endtask

    task automatic test_watchdog();
        logic [7:0] d;
        logic       ol, oh;
        bus_write(16'h1101, 8'h22);
        tests++; if (mot_vel[15:0] !== 16'h7F22) begin fails++; $display("FAIL wd_vel_live: got %h expected 7f22", mot_vel[15:0]); end
        repeat (14) tick();
        tests++; if (wdog_trip !== 1'b0) begin fails++; $display("FAIL wd_early: got %b expected 0", wdog_trip); end
        tick();
        tests++; if (wdog_trip !== 1'b1) begin fails++; $display("FAIL wd_trip: got %b expected 1", wdog_trip); end
        tests++; if (mot_vel !== 48'h0) begin fails++; $display("FAIL wd_vel_masked: got %h expected 0", mot_vel); end
        bus_read(16'h1101, d, ol, oh);
        tests++; if (d !== 8'h22) begin fails++; $display("FAIL wd_reg_kept: got %h expected 22", d); end
        bus_read(16'h11C1, d, ol, oh);
        tests++; if (d !== 8'h01) begin fails++; $display("FAIL wd_status: got %h expected 01", d); end
        tests++; if (wdog_trip !== 1'b1) begin fails++; $display("FAIL wd_read_keeps: got %b expected 1", wdog_trip); end
        bus_write(16'h1100, 8'h03);
        tests++; if (wdog_trip !== 1'b0) begin fails++; $display("FAIL wd_clear: got %b expected 0", wdog_trip); end
        tests++; if (mot_vel[15:0] !== 16'h7F22) begin fails++; $display("FAIL wd_vel_restored: got %h expected 7f22", mot_vel[15:0]); end
        tests++; if (mot_ctl[1:0] !== 2'b11) begin fails++; $display("FAIL wd_ctl0: got %b expected 11", mot_ctl[1:0]); end
    endtask

    task automatic test_version_decode();
        logic [7:0] d;
        logic       ol, oh;
        bus_read(16'h11FF, d, ol, oh);
        tests++; if (d !== 8'h5A) begin fails++; $display("FAIL ver_min: got %h expected 5a", d); end
        tests++; if (ol !== 1'b1) begin fails++; $display("FAIL ver_oe_low: got %b expected 1", ol); end
        tests++; if (oh !== 1'b0) begin fails++; $display("FAIL ver_oe_high: got %b expected 0", oh); end
        tests++; if (aout !== 8'hFF) begin fails++; $display("FAIL ver_aout: got %h expected ff", aout); end
        bus_read(16'h11FE, d, ol, oh);
        tests++; if (d !== 8'hA1) begin fails++; $display("FAIL ver_maj: got %h expected a1", d); end
        bus_read(16'h0300, d, ol, oh);
        tests++; if (ol !== 1'b0) begin fails++; $display("FAIL miss_oe: got %b expected 0", ol); end
        tests++; if (ramce !== 1'b1) begin fails++; $display("FAIL miss_ramce: got %b expected 1", ramce); end
        bus_read(16'h8040, d, ol, oh);
        tests++; if (ramce !== 1'b0) begin fails++; $display("FAIL hi_ramce: got %b expected 0", ramce); end
        tests++; if (aout !== 8'h40) begin fails++; $display("FAIL hi_aout: got %h expected 40", aout); end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] d;
        logic       ol, oh;
        start_write(16'h1105, 8'h66);
        nRST = 1'b0;
        #1;
        tests++; if (ad_oe !== 1'b0) begin fails++; $display("FAIL rst_wr_oe: got %b expected 0", ad_oe); end
        tick();
        nWR  = 1'b1;
        nRST = 1'b1;
        repeat (5) tick();
        tests++; if (mot_vel[23:16] !== 8'h00) begin fails++; $display("FAIL rst_wr_vel: got %h expected 00", mot_vel[23:16]); end
        tests++; if (mot_vel[15:8] !== 8'h00) begin fails++; $display("FAIL rst_wr_vel1_cleared: got %h expected 00", mot_vel[15:8]); end
        bus_read(16'h1105, d, ol, oh);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL rst_wr_read: got %h expected 00", d); end
        tests++; if (ol !== 1'b1) begin fails++; $display("FAIL rst_wr_idle_oe: got %b expected 1", ol); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_write_read_vel();
        test_encoder();
        test_servo();
        test_watchdog();
        test_version_decode();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
